// File: rtl/vga_cmd_parser.sv
// UART command parser for a VGA test-pattern generator.
// Accepts "P<h><CR>" (set pattern) and, when VGA_CMD_COLOR_EN is defined,
// "C<h><h><h><CR>" (set solid colour). Each completed or rejected command is
// answered with one 'K' or 'E' byte. A partial command is dropped silently
// after TIMEOUT_CLKS clocks without a byte (TIMEOUT_CLKS must be >= 2).
module vga_cmd_parser #(
  parameter int unsigned TIMEOUT_CLKS = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_TX_Active,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  output logic [3:0] o_Pattern,
  output logic       o_Pattern_Valid,
  output logic [3:0] o_Red,
  output logic [3:0] o_Grn,
  output logic [3:0] o_Blu,
  output logic       o_Cmd_Err
);

`ifdef VGA_CMD_COLOR_EN
  localparam bit          ColorEn = 1'b1;
  localparam int unsigned ArgW    = 12;
`else
  localparam bit          ColorEn = 1'b0;
  localparam int unsigned ArgW    = 4;
`endif

  localparam int unsigned     CntW   = $clog2(TIMEOUT_CLKS);
  localparam logic [CntW-1:0] TmoMax = CntW'(TIMEOUT_CLKS - 1);

  localparam logic [7:0] ChCr = 8'h0D;
  localparam logic [7:0] ChLf = 8'h0A;
  localparam logic [7:0] ChK  = 8'h4B;
  localparam logic [7:0] ChE  = 8'h45;

  typedef enum logic [1:0] {StIdle, StGetArg, StWaitCr, StRespond} state_e;

  state_e          state_q, state_d;
  logic [1:0]      arg_cnt_q, arg_cnt_d;
  logic            is_color_q, is_color_d;
  logic [ArgW-1:0] arg_q, arg_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic [3:0]      pattern_q, pattern_d;
  logic            pattern_valid_q, pattern_valid_d;
  logic            cmd_err_q, cmd_err_d;
  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            commit_color;
  logic            hex_ok;
  logic [3:0]      hex_val;
  logic            is_p, is_c, timeout;

  // Hex digit decode of the incoming byte.
  always_comb begin
    hex_ok  = 1'b1;
    hex_val = 4'h0;
    if (i_RX_Byte >= 8'h30 && i_RX_Byte <= 8'h39) begin
      hex_val = 4'(i_RX_Byte - 8'h30);
    end else if (i_RX_Byte >= 8'h41 && i_RX_Byte <= 8'h46) begin
      hex_val = 4'(i_RX_Byte - 8'h37);
    end else if (i_RX_Byte >= 8'h61 && i_RX_Byte <= 8'h66) begin
      hex_val = 4'(i_RX_Byte - 8'h57);
    end else begin
      hex_ok = 1'b0;
    end
  end

  assign is_p    = (i_RX_Byte == 8'h50) || (i_RX_Byte == 8'h70);
  assign is_c    = ColorEn && ((i_RX_Byte == 8'h43) || (i_RX_Byte == 8'h63));
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout = ((state_q == StGetArg) || (state_q == StWaitCr)) && !i_RX_DV &&
                   (tmo_cnt_q == TmoMax);

  // Silence counter: cleared by every byte, saturates instead of wrapping.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (i_RX_DV) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TmoMax) begin
      tmo_cnt_d = tmo_cnt_q + CntW'(1);
    end
  end

  // Next-state and output decode for the command FSM.
  always_comb begin
    state_d         = state_q;
    arg_cnt_d       = arg_cnt_q;
    is_color_d      = is_color_q;
    arg_d           = arg_q;
    tx_byte_d       = tx_byte_q;
    pattern_d       = pattern_q;
    pattern_valid_d = 1'b0;
    cmd_err_d       = 1'b0;
    commit_color    = 1'b0;
    o_TX_DV         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_RX_DV) begin
          if (is_p || is_c) begin
            state_d    = StGetArg;
            arg_cnt_d  = is_c ? 2'd3 : 2'd1;
            is_color_d = is_c;
          end else if (i_RX_Byte != ChCr && i_RX_Byte != ChLf) begin
            state_d   = StRespond;
            tx_byte_d = ChE;
            cmd_err_d = 1'b1;
          end
        end
      end
      StGetArg: begin
        if (i_RX_DV) begin
          if (hex_ok) begin
            // Digits shift in from the right: R ends up in the top nibble.
            arg_d     = ArgW'({arg_q, hex_val});
            arg_cnt_d = arg_cnt_q - 2'd1;
            if (arg_cnt_q == 2'd1) begin
              state_d = StWaitCr;
            end
          end else begin
            state_d   = StRespond;
            tx_byte_d = ChE;
            cmd_err_d = 1'b1;
          end
        end else if (timeout) begin
          state_d   = StIdle;
          cmd_err_d = 1'b1;
        end
      end
      StWaitCr: begin
        if (i_RX_DV) begin
          state_d = StRespond;
          if (i_RX_Byte == ChCr) begin
            tx_byte_d = ChK;
            if (is_color_q) begin
              commit_color = 1'b1;
            end else begin
              pattern_d       = arg_q[3:0];
              pattern_valid_d = 1'b1;
            end
          end else begin
            tx_byte_d = ChE;
            cmd_err_d = 1'b1;
          end
        end else if (timeout) begin
          state_d   = StIdle;
          cmd_err_d = 1'b1;
        end
      end
      StRespond: begin
        // Incoming bytes are ignored here.
        if (!i_TX_Active) begin
          o_TX_DV = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and datapath registers.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q         <= StIdle;
      arg_cnt_q       <= 2'd0;
      is_color_q      <= 1'b0;
      arg_q           <= '0;
      tx_byte_q       <= 8'h00;
      pattern_q       <= 4'h0;
      pattern_valid_q <= 1'b0;
      cmd_err_q       <= 1'b0;
      tmo_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      arg_cnt_q       <= arg_cnt_d;
      is_color_q      <= is_color_d;
      arg_q           <= arg_d;
      tx_byte_q       <= tx_byte_d;
      pattern_q       <= pattern_d;
      pattern_valid_q <= pattern_valid_d;
      cmd_err_q       <= cmd_err_d;
      tmo_cnt_q       <= tmo_cnt_d;
    end
  end

`ifdef VGA_CMD_COLOR_EN
  logic [3:0] red_q, grn_q, blu_q;

  // Colour registers, loaded when a colour command is confirmed by CR.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      red_q <= 4'h0;
      grn_q <= 4'h0;
      blu_q <= 4'h0;
    end else if (commit_color) begin
      red_q <= arg_q[11:8];
      grn_q <= arg_q[7:4];
      blu_q <= arg_q[3:0];
    end
  end

  assign o_Red = red_q;
  assign o_Grn = grn_q;
  assign o_Blu = blu_q;
`else
  logic unused_commit_color;
  assign unused_commit_color = commit_color;
  assign o_Red = 4'h0;
  assign o_Grn = 4'h0;
  assign o_Blu = 4'h0;
`endif

  assign o_TX_Byte       = tx_byte_q;
  assign o_Pattern       = pattern_q;
  assign o_Pattern_Valid = pattern_valid_q;
  assign o_Cmd_Err       = cmd_err_q;

endmodule
